// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// The FSM side (master) reads the opcode and ALU zero flag and drives every
// mux select and write enable; the datapath side (slave) does the reverse.
interface multicycle_main_fsm_if;
  logic [6:0] op;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       RegWrite;
  logic [3:0] state_o;

  modport master (
    input  op, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, RegWrite, state_o
  );

  modport slave (
    output op, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, RegWrite, state_o
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V core. Sequences each instruction
// through Fetch/Decode/Execute/Memory/Writeback, one state per clock, and
// drives the datapath selects, write enables and the ALUOp field.
module multicycle_main_fsm (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_main_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_e     state_q, state_d;

  logic       pc_update;
  logic       branch;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  // State register; reset drops straight back to FETCH without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, no ordering races.
      state_q <= state_d;
    end
  end

  // Next-state decode and Moore outputs for the current state.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        // PC + 4 computed and written while the instruction is latched.
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm: branch/jump target parked in ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        // rs1 - rs2 sets Zero; the target from DECODE sits on ALUOut.
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // OldPC + 4 is the link value; PC takes the target from ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: begin
        // Codes 11-15: all outputs idle, recover to FETCH.
        state_d = S_FETCH;
      end
    endcase
  end

  // Write enables are gated by reset so nothing commits while it is held.
  assign bus.PCWrite   = ~reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite   = ~reset & ir_write;
  assign bus.MemWrite  = ~reset & mem_write;
  assign bus.RegWrite  = ~reset & reg_write;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm. Stimulus drives op/Zero/reset
// just after each rising edge and queues the outputs expected for that cycle;
// a monitor samples the DUT on each falling edge and compares.
module tb_multicycle_main_fsm;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
  } out_t;

  typedef struct {
    string tag;
    out_t  v;
  } sb_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk;
  logic reset;
  sb_t  sb[$];
  int   total;
  int   bad;

  multicycle_main_fsm_if bus ();

  multicycle_main_fsm dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs the specification lists for each state (unlisted = 0).
  function automatic out_t expect_out(input logic [3:0] st, input logic z, input logic rst);
    out_t e;
    e = '0;
    e.state = st;
    case (st)
      4'd0:  begin e.ir_write = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10; e.pc_write = 1'b1; end
      4'd1:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
      4'd2:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      4'd3:  begin e.adr_src = 1'b1; end
      4'd4:  begin e.result_src = 2'b01; e.reg_write = 1'b1; end
      4'd5:  begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
      4'd6:  begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
      4'd7:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
      4'd8:  begin e.reg_write = 1'b1; end
      4'd9:  begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; end
      4'd10: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      e.pc_write  = 1'b0;
      e.ir_write  = 1'b0;
      e.mem_write = 1'b0;
      e.reg_write = 1'b0;
    end
    return e;
  endfunction

  // One clock of stimulus plus the expectation for that clock.
  task automatic step(input logic rst_v, input logic [6:0] op_v, input logic z_v,
                      input logic [3:0] st, input string tag);
    sb_t item;
    @(posedge clk);
    #1;
    reset   = rst_v;
    bus.op  = op_v;
    bus.Zero = z_v;
    item.tag = tag;
    item.v   = expect_out(st, z_v, rst_v);
    sb.push_back(item);
  endtask

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t  e;
      out_t a;
      e = sb.pop_front();
      a.state      = bus.state_o;
      a.pc_write   = bus.PCWrite;
      a.adr_src    = bus.AdrSrc;
      a.mem_write  = bus.MemWrite;
      a.ir_write   = bus.IRWrite;
      a.result_src = bus.ResultSrc;
      a.alu_src_a  = bus.ALUSrcA;
      a.alu_src_b  = bus.ALUSrcB;
      a.alu_op     = bus.ALUOp;
      a.reg_write  = bus.RegWrite;
      total++;
      if (a !== e.v) begin
        bad++;
        $display("FAIL %s: got state=%0d out=%h, want state=%0d out=%h",
                 e.tag, a.state, a, e.v.state, e.v);
      end
    end
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    bus.op   = 7'd0;
    bus.Zero = 1'b0;

    // Reset held for three clocks: FETCH selects, enables gated.
    step(1, 7'd0, 1, 4'd0, "rst0");
    step(1, 7'd0, 1, 4'd0, "rst1");
    step(1, 7'd0, 1, 4'd0, "rst2");

    // lw; op is disturbed in MEMREAD, which must be ignored.
    step(0, LW, 0, 4'd0, "lw_fetch");
    step(0, LW, 0, 4'd1, "lw_decode");
    step(0, LW, 0, 4'd2, "lw_memadr");
    step(0, BAD, 0, 4'd3, "lw_memread");
    step(0, BAD, 0, 4'd4, "lw_memwb");

    // sw
    step(0, SW, 0, 4'd0, "sw_fetch");
    step(0, SW, 0, 4'd1, "sw_decode");
    step(0, SW, 0, 4'd2, "sw_memadr");
    step(0, SW, 0, 4'd5, "sw_memwrite");

    // R-type with a Zero glitch that must not reach PCWrite
    step(0, RT, 1, 4'd0, "r_fetch");
    step(0, RT, 1, 4'd1, "r_decode");
    step(0, RT, 1, 4'd6, "r_execute");
    step(0, RT, 1, 4'd8, "r_aluwb");

    // I-type
    step(0, IT, 0, 4'd0, "i_fetch");
    step(0, IT, 0, 4'd1, "i_decode");
    step(0, IT, 0, 4'd7, "i_execute");
    step(0, IT, 0, 4'd8, "i_aluwb");

    // beq taken then not taken
    step(0, BQ, 0, 4'd0, "beq1_fetch");
    step(0, BQ, 0, 4'd1, "beq1_decode");
    step(0, BQ, 1, 4'd9, "beq1_taken");
    step(0, BQ, 1, 4'd0, "beq0_fetch");
    step(0, BQ, 1, 4'd1, "beq0_decode");
    step(0, BQ, 0, 4'd9, "beq0_not_taken");

    // jal
    step(0, JL, 0, 4'd0, "jal_fetch");
    step(0, JL, 0, 4'd1, "jal_decode");
    step(0, JL, 0, 4'd10, "jal_jump");
    step(0, JL, 0, 4'd8, "jal_aluwb");

    // unsupported opcode: straight back to FETCH
    step(0, BAD, 0, 4'd0, "bad_fetch");
    step(0, BAD, 0, 4'd1, "bad_decode");
    step(0, LW, 0, 4'd0, "bad_next_fetch");

    // lw aborted by reset in MEMADR, then completed cleanly
    step(0, LW, 0, 4'd1, "abort_decode");
    step(0, LW, 0, 4'd2, "abort_memadr");
    step(1, LW, 1, 4'd0, "abort_rst0");
    step(1, LW, 1, 4'd0, "abort_rst1");
    step(1, LW, 1, 4'd0, "abort_rst2");
    step(0, LW, 0, 4'd0, "rel_fetch");
    step(0, LW, 0, 4'd1, "rel_decode");
    step(0, LW, 0, 4'd2, "rel_memadr");
    step(0, LW, 0, 4'd3, "rel_memread");
    step(0, LW, 0, 4'd4, "rel_memwb");
    step(0, LW, 0, 4'd0, "rel_next_fetch");

    // Let the monitor drain the last expectation.
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
